// File: rtl/alu_if.sv
// alu_if: operand/opcode inputs and result outputs of the execute-stage ALU.
// Overflow exists only when ALU_OVF_EN is defined.
interface alu_if;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUop;
    logic [31:0] Out;
    logic [31:0] OutQ;
    logic        IllegalOp;
`ifdef ALU_OVF_EN
    logic        Overflow;
`endif

    modport master (
        output opcode,
        output funct,
        output A,
        output B,
        input  ALUop,
        input  Out,
        input  OutQ,
`ifdef ALU_OVF_EN
        input  Overflow,
`endif
        input  IllegalOp
    );

    modport slave (
        input  opcode,
        input  funct,
        input  A,
        input  B,
        output ALUop,
        output Out,
        output OutQ,
`ifdef ALU_OVF_EN
        output Overflow,
`endif
        output IllegalOp
    );
endinterface

// File: rtl/alu.sv
// alu: MIPS150 execute-stage ALU with built-in opcode/funct decode.
// Define ALU_OVF_EN to add the signed-overflow output for ADDU/SUBU.
module alu (
    input  logic Clock,
    input  logic Reset,
    alu_if.slave bus
);
    typedef enum logic [3:0] {
        OP_ADDU = 4'd0,
        OP_SUBU = 4'd1,
        OP_SLT  = 4'd2,
        OP_SLTU = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_LUI  = 4'd7,
        OP_SLL  = 4'd8,
        OP_SRA  = 4'd9,
        OP_SRL  = 4'd10,
        OP_NOR  = 4'd11,
        OP_XXX  = 4'd15
    } alu_op_e;

    alu_op_e     op;
    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] res;
    logic [4:0]  shamt;
    logic [31:0] out_q;
    logic        illegal_q;

    always_comb begin
        op = OP_XXX;
        if (bus.opcode == 6'b000000) begin
            unique case (bus.funct)
                6'b100001:            op = OP_ADDU;
                6'b100011:            op = OP_SUBU;
                6'b101010:            op = OP_SLT;
                6'b101011:            op = OP_SLTU;
                6'b100100:            op = OP_AND;
                6'b100101:            op = OP_OR;
                6'b100110:            op = OP_XOR;
                6'b100111:            op = OP_NOR;
                6'b000000, 6'b000100: op = OP_SLL;
                6'b000010, 6'b000110: op = OP_SRL;
                6'b000011, 6'b000111: op = OP_SRA;
                default:              op = OP_XXX;
            endcase
        end else begin
            // loads, stores and ADDIU all compute base + offset
            unique case (bus.opcode)
                6'b100000, 6'b100001, 6'b100011,
                6'b100100, 6'b100101, 6'b101000,
                6'b101001, 6'b101011, 6'b001001:
                    op = OP_ADDU;
                6'b001010: op = OP_SLT;
                6'b001011: op = OP_SLTU;
                6'b001100: op = OP_AND;
                6'b001101: op = OP_OR;
                6'b001110: op = OP_XOR;
                6'b001111: op = OP_LUI;
                default:   op = OP_XXX;
            endcase
        end
    end

    assign sum   = bus.A + bus.B;
    assign diff  = bus.A - bus.B;
    assign shamt = bus.A[4:0];

    always_comb begin
        res = 32'h0000_0000;
        unique case (op)
            OP_ADDU: res = sum;
            OP_SUBU: res = diff;
            OP_SLT:  res = {31'b0, $signed(bus.A) < $signed(bus.B)};
            OP_SLTU: res = {31'b0, bus.A < bus.B};
            OP_AND:  res = bus.A & bus.B;
            OP_OR:   res = bus.A | bus.B;
            OP_XOR:  res = bus.A ^ bus.B;
            OP_NOR:  res = ~(bus.A | bus.B);
            OP_LUI:  res = {bus.B[15:0], 16'h0000};
            OP_SLL:  res = bus.B << shamt;
            OP_SRL:  res = bus.B >> shamt;
            OP_SRA:  res = $unsigned($signed(bus.B) >>> shamt);
            default: res = 32'h0000_0000;
        endcase
    end

    assign bus.ALUop = op;
    assign bus.Out   = res;

`ifdef ALU_OVF_EN
    logic ovf;

    always_comb begin
        ovf = 1'b0;
        unique case (op)
            OP_ADDU: ovf = (bus.A[31] == bus.B[31]) &&
                           (sum[31] != bus.A[31]);
            OP_SUBU: ovf = (bus.A[31] != bus.B[31]) &&
                           (diff[31] != bus.A[31]);
            default: ovf = 1'b0;
        endcase
    end

    assign bus.Overflow = ovf;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            out_q     <= 32'h0000_0000;
            illegal_q <= 1'b0;
        end else begin
            out_q     <= res;
            illegal_q <= illegal_q | (op == OP_XXX);
        end
    end

    assign bus.OutQ      = out_q;
    assign bus.IllegalOp = illegal_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed spec vectors plus randomized stimulus against
// an arithmetic reference model of decode, result and sticky state.
module tb_alu;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [31:0] m_q;
    logic        m_ill;

    alu_if bus ();

    alu dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_op(input logic [5:0] op,
                                          input logic [5:0] fn);
        if (op == 6'd0) begin
            if (fn == 6'b100001) return 4'd0;
            if (fn == 6'b100011) return 4'd1;
            if (fn == 6'b101010) return 4'd2;
            if (fn == 6'b101011) return 4'd3;
            if (fn == 6'b100100) return 4'd4;
            if (fn == 6'b100101) return 4'd5;
            if (fn == 6'b100110) return 4'd6;
            if (fn == 6'b100111) return 4'd11;
            if (fn inside {6'b000000, 6'b000100}) return 4'd8;
            if (fn inside {6'b000010, 6'b000110}) return 4'd10;
            if (fn inside {6'b000011, 6'b000111}) return 4'd9;
            return 4'd15;
        end
        if (op inside {6'b100000, 6'b100001, 6'b100011, 6'b100100,
                       6'b100101, 6'b101000, 6'b101001, 6'b101011,
                       6'b001001})
            return 4'd0;
        if (op == 6'b001010) return 4'd2;
        if (op == 6'b001011) return 4'd3;
        if (op == 6'b001100) return 4'd4;
        if (op == 6'b001101) return 4'd5;
        if (op == 6'b001110) return 4'd6;
        if (op == 6'b001111) return 4'd7;
        return 4'd15;
    endfunction

    function automatic logic [31:0] ref_out(input logic [3:0] e,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [4:0]  sh;
        logic [63:0] p;
        longint      sa;
        longint      sb;
        sh = a[4:0];
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (e)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd3:  return ({32'b0, a} < {32'b0, b}) ? 32'd1 : 32'd0;
            4'd4:  return a & b;
            4'd5:  return a | b;
            4'd6:  return a ^ b;
            4'd11: return ~(a | b);
            4'd7:  return {b[15:0], 16'h0000};
            4'd8: begin
                p = {32'b0, b} * (64'd1 << sh);
                return p[31:0];
            end
            4'd10: return b / (32'd1 << sh);
            4'd9:  return b[31] ? ~((~b) / (32'd1 << sh))
                                : b / (32'd1 << sh);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [3:0] e,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
        longint s;
        if (e == 4'd0)
            s = longint'($signed(a)) + longint'($signed(b));
        else if (e == 4'd1)
            s = longint'($signed(a)) - longint'($signed(b));
        else
            return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    task automatic step(input logic [5:0] op,
                        input logic [5:0] fn,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic r);
        logic [3:0]  eop;
        logic [31:0] eout;
        bus.opcode = op;
        bus.funct  = fn;
        bus.A      = a;
        bus.B      = b;
        rst        = r;
        #1;
        eop  = ref_op(op, fn);
        eout = ref_out(eop, a, b);
        check("aluop", {28'b0, bus.ALUop}, {28'b0, eop});
        check("out", bus.Out, eout);
`ifdef ALU_OVF_EN
        check("ovf", {31'b0, bus.Overflow}, {31'b0, ref_ovf(eop, a, b)});
`endif
        @(posedge clk);
        if (r) begin
            m_q   = 32'h0;
            m_ill = 1'b0;
        end else begin
            m_q   = eout;
            m_ill = m_ill | (eop == 4'd15);
        end
        #1;
        check("outq", bus.OutQ, m_q);
        check("illegal", {31'b0, bus.IllegalOp}, {31'b0, m_ill});
    endtask

    logic [5:0] legal_ops [16] = '{
        6'b100000, 6'b100001, 6'b100011, 6'b100100,
        6'b100101, 6'b101000, 6'b101001, 6'b101011,
        6'b001001, 6'b001010, 6'b001011, 6'b001100,
        6'b001101, 6'b001110, 6'b001111, 6'b000100
    };
    logic [5:0] r_functs [16] = '{
        6'b100001, 6'b100011, 6'b101010, 6'b101011,
        6'b100100, 6'b100101, 6'b100110, 6'b100111,
        6'b000000, 6'b000100, 6'b000010, 6'b000110,
        6'b000011, 6'b000111, 6'b100000, 6'b001000
    };
    logic [31:0] edge_vals [6] = '{
        32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
        32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_001F
    };

    function automatic logic [31:0] pick_val();
        if ($urandom_range(0, 3) == 0)
            return edge_vals[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        total      = 0;
        bad        = 0;
        m_q        = 32'h0;
        m_ill      = 1'b0;
        rst        = 1'b1;
        bus.opcode = 6'd0;
        bus.funct  = 6'd0;
        bus.A      = 32'd0;
        bus.B      = 32'd0;
        #2;

        step(6'b000000, 6'b100001, 32'hFFFF_FFFF, 32'h1, 1'b1);
        step(6'b000000, 6'b100001, 32'hFFFF_FFFF, 32'h1, 1'b0);
        check("wrap", bus.Out, 32'h0);
        step(6'b000000, 6'b101010, 32'h8000_0000, 32'h1, 1'b0);
        step(6'b000000, 6'b101011, 32'h8000_0000, 32'h1, 1'b0);
        step(6'b000000, 6'b000011, 32'h4, 32'hF000_0000, 1'b0);
        step(6'b000000, 6'b000010, 32'h4, 32'hF000_0000, 1'b0);
        step(6'b001111, 6'b000000, 32'h0, 32'h0000_ABCD, 1'b0);
        step(6'b100011, 6'b000000, 32'h100, 32'hFFFF_FFFC, 1'b0);
        step(6'b000000, 6'b100011, 32'h8000_0000, 32'h1, 1'b0);
        step(6'b000000, 6'b100001, 32'h7FFF_FFFF, 32'h1, 1'b0);
        step(6'b000000, 6'b100100, 32'h7FFF_FFFF, 32'h1, 1'b0);
        step(6'b000100, 6'b000000, 32'h5, 32'h6, 1'b0);
        step(6'b000000, 6'b100001, 32'h1, 32'h2, 1'b0);
        step(6'b000000, 6'b100101, 32'h1, 32'h2, 1'b0);
        step(6'b000100, 6'b000000, 32'h5, 32'h6, 1'b1);
        step(6'b000000, 6'b000000, 32'hFFFF_FFE1, 32'h1, 1'b0);
        step(6'b000000, 6'b111111, 32'h1, 32'h1, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    op = 6'd0;
                    fn = r_functs[$urandom_range(0, 15)];
                end
                1: begin
                    op = legal_ops[$urandom_range(0, 15)];
                    fn = 6'($urandom);
                end
                2: begin
                    op = 6'd0;
                    fn = 6'($urandom);
                end
                default: begin
                    op = 6'($urandom);
                    fn = 6'($urandom);
                end
            endcase
            a = pick_val();
            b = pick_val();
            step(op, fn, a, b, $urandom_range(0, 15) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
